cache_bank_switch_ctrl: RTL
===========================

CACHE_BANK_SWITCH_CTRL -- requirements
Module: cache_bank_switch_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of cache banks (contexts), legal range 2..16.
REQ-002 SHALL have parameter BANK_W, default 2: bank-id width, satisfying 2^BANK_W >= NUM_BANKS.
REQ-003 SHALL have parameter NUM_LINES, default 8: lines per bank scanned for writeback.
REQ-004 SHALL have parameter IDX_W, default 3: line-index width, satisfying 2^IDX_W >= NUM_LINES.
REQ-005 SHALL have parameter WB_MODE, default 1: 1 = write back dirty lines before the switch; 0 = switch without writeback.
REQ-006 SHALL have port clk  in  1  the single clock, all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
REQ-008 SHALL have port switch_req  in  1  one-cycle switch command from the MEM stage (switch_cache_w).
REQ-009 SHALL have port switch_bank  in  BANK_W  target bank id, valid while switch_req=1.
REQ-010 SHALL have port mem_busywait  in  1  data cache access in progress.
REQ-011 SHALL have port dirty_vec  in  NUM_LINES  dirty bits of the active bank.
REQ-012 SHALL have port wb_ack  in  1  one-cycle writeback-complete acknowledge.
REQ-013 SHALL have port wb_req  out  1  writeback request for line wb_idx.
REQ-014 SHALL have port wb_idx  out  IDX_W  line index under scan or writeback.
REQ-015 SHALL have port active_bank  out  BANK_W  bank currently selected.
REQ-016 SHALL have port switch_busywait  out  1  pipeline stall.
REQ-017 SHALL have port switch_done  out  1  one-cycle completion pulse.
REQ-018 SHALL have port switch_err  out  1  one-cycle invalid-bank pulse.
REQ-019 SHALL have port switch_count  out  16  count of completed bank changes, wrapping 0xFFFF->0.

Function
REQ-020 SHALL implement a Moore FSM with states IDLE, DRAIN, SCAN, WB, COMMIT.
REQ-021 IDLE: switch_req=1 with switch_bank>=NUM_BANKS SHALL pulse switch_err in the next cycle and remain in IDLE.
REQ-022 IDLE: switch_req=1 with switch_bank==active_bank SHALL go to COMMIT with no writeback and no count increment.
REQ-023 IDLE: switch_req=1 with a valid, different bank SHALL latch the target and go to DRAIN.
REQ-024 DRAIN SHALL hold while mem_busywait=1; when it is 0, SHALL go to SCAN with wb_idx=0 if WB_MODE=1, else to COMMIT.
REQ-025 SCAN: if dirty_vec[wb_idx]=1, SHALL go to WB.
REQ-026 SCAN: if the line is clean and wb_idx==NUM_LINES-1, SHALL go to COMMIT; otherwise SHALL increment wb_idx and stay in SCAN (one line per cycle).
REQ-027 WB SHALL hold wb_req=1 until wb_ack=1; on ack SHALL go to COMMIT if wb_idx==NUM_LINES-1, else increment wb_idx and go to SCAN.
REQ-028 wb_req SHALL be 1 only in WB.
REQ-029 wb_ack outside WB SHALL be ignored.
REQ-030 COMMIT SHALL assert switch_done for exactly that cycle and return to IDLE.
REQ-031 On leaving COMMIT for a bank change, active_bank SHALL take the target and switch_count SHALL increment.
REQ-032 switch_busywait SHALL be 1 whenever state!=IDLE.
REQ-033 In IDLE, switch_busywait SHALL also be 1, combinationally, in any cycle where switch_req=1 and switch_bank<NUM_BANKS.
REQ-034 switch_req while not in IDLE SHALL be ignored: no queuing, no error.
REQ-035 dirty_vec SHALL be sampled live at each SCAN cycle and is not latched.

Reset
REQ-036 With reset=0 at a rising edge, in any state including mid-WB, the block SHALL return to IDLE.
REQ-037 On reset, the block SHALL set active_bank=0, wb_idx=0, switch_count=0, and wb_req=switch_done=switch_err=switch_busywait=0 in the following cycle.
REQ-038 A writeback in progress at reset SHALL be abandoned without a completion pulse.

Verification
REQ-039 Reset, then switch_req with bank=2, WB_MODE=1, dirty_vec=0, mem_busywait=0 -> DRAIN at cycle 1, SCAN cycles 2-9, switch_done at cycle 10, active_bank=2 and switch_count=1 at cycle 11, busywait high cycles 0-10.
REQ-040 Bank 1 to bank 3 with dirty_vec=8'b1000_0100, wb_ack 3 cycles after each wb_req -> wb_req with wb_idx=2 then 7, switch_done after the second ack, active_bank=3.
REQ-041 switch_req with bank=1 while mem_busywait=1 for 5 cycles -> FSM stays in DRAIN for 5 cycles, with no wb_req or switch_done before it is released.
REQ-042 NUM_BANKS=3, switch_req with bank=3 -> switch_err pulse, active_bank unchanged, busywait never asserted; a same-bank request -> switch_done, count unchanged.
REQ-043 reset=0 asserted during WB -> next cycle IDLE, wb_req=0, active_bank=0; a second switch_req issued during SCAN -> ignored.

Source files
------------

// File: rtl/cache_bank_switch_ctrl_if.sv
// Bank-switch control bus between the pipeline/cache side and the switch
// controller. The master drives switch commands, memory status and writeback
// acknowledges. The slave (controller) drives the writeback requests, the
// selected bank and the status outputs.
interface cache_bank_switch_ctrl_if #(
  parameter int BANK_W    = 2,
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
);
  logic                 switch_req;
  logic [BANK_W-1:0]    switch_bank;
  logic                 mem_busywait;
  logic [NUM_LINES-1:0] dirty_vec;
  logic                 wb_ack;
  logic                 wb_req;
  logic [IDX_W-1:0]     wb_idx;
  logic [BANK_W-1:0]    active_bank;
  logic                 switch_busywait;
  logic                 switch_done;
  logic                 switch_err;
  logic [15:0]          switch_count;

  modport master (
    output switch_req, switch_bank, mem_busywait, dirty_vec, wb_ack,
    input  wb_req, wb_idx, active_bank, switch_busywait, switch_done,
           switch_err, switch_count
  );

  modport slave (
    input  switch_req, switch_bank, mem_busywait, dirty_vec, wb_ack,
    output wb_req, wb_idx, active_bank, switch_busywait, switch_done,
           switch_err, switch_count
  );
endinterface

// File: rtl/cache_bank_switch_ctrl.sv
// Cache bank (context) switch controller. It accepts a switch command and
// drains the in-flight data cache access. Unless writeback is disabled, it
// then scans the active bank one line per cycle and writes back each dirty line
// through a req/ack handshake. Finally it commits the new bank and pulses
// switch_done. The interface instance must use the same BANK_W, NUM_LINES and
// IDX_W as this module.
module cache_bank_switch_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int WB_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_bank_switch_ctrl_if.slave bus
);

  localparam logic [BANK_W:0]  NB_LIMIT = (BANK_W+1)'(NUM_BANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SCAN   = 3'd2,
    WB     = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t            state_reg;
  logic [BANK_W-1:0] target_reg;
  logic [BANK_W-1:0] active_reg;
  logic              change_reg;   // commit really changes the bank
  logic [IDX_W-1:0]  idx_reg;
  logic [15:0]       count_reg;
  logic              wb_req_reg;
  logic              done_reg;
  logic              err_reg;
  logic              busy_reg;
  logic              bank_ok;

  // A request names a real bank only below NUM_BANKS; the extra MSB keeps the
  // compare correct when NUM_BANKS == 2**BANK_W.
  assign bank_ok = ({1'b0, bus.switch_bank} < NB_LIMIT);

  // Switch sequencer: state, scan index, bank/count bookkeeping and all
  // registered status outputs are updated together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      active_reg <= '0;
      change_reg <= 1'b0;
      idx_reg    <= '0;
      count_reg  <= '0;
      wb_req_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.switch_req) begin
            if (!bank_ok) begin
              err_reg <= 1'b1;
            end else if (bus.switch_bank == active_reg) begin
              // Same bank: nothing to flush, just acknowledge.
              target_reg <= active_reg;
              change_reg <= 1'b0;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b1;
              state_reg  <= COMMIT;
            end else begin
              target_reg <= bus.switch_bank;
              change_reg <= 1'b1;
              busy_reg   <= 1'b1;
              state_reg  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!bus.mem_busywait) begin
            if (WB_MODE != 0) begin
              idx_reg   <= '0;
              state_reg <= SCAN;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= COMMIT;
            end
          end
        end
        SCAN: begin
          // dirty_vec is looked at live, one line per cycle.
          if (bus.dirty_vec[idx_reg]) begin
            wb_req_reg <= 1'b1;
            state_reg  <= WB;
          end else if (idx_reg == LAST_IDX) begin
            done_reg  <= 1'b1;
            state_reg <= COMMIT;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        WB: begin
          if (bus.wb_ack) begin
            wb_req_reg <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              done_reg  <= 1'b1;
              state_reg <= COMMIT;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= SCAN;
            end
          end
        end
        COMMIT: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
          if (change_reg) begin
            active_reg <= target_reg;
            count_reg  <= count_reg + 16'd1;
          end
        end
        default: begin
          wb_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign bus.wb_req      = wb_req_reg;
  assign bus.wb_idx      = idx_reg;
  assign bus.active_bank = active_reg;
  assign bus.switch_done = done_reg;
  assign bus.switch_err  = err_reg;
  assign bus.switch_count = count_reg;

  // The stall must already be high in the cycle a valid command arrives, so
  // the pipeline freezes before the FSM has left IDLE.
  assign bus.switch_busywait = busy_reg |
                               ((state_reg == IDLE) & bus.switch_req & bank_ok);

endmodule
